// File: rtl/gf256_inv_sched.sv
// Issue scheduler, LFSR freshness source and in-order result FIFO for a
// non-stallable 2-share masked GF(2^8) inverse pipeline.
module gf256_inv_sched #(
  parameter int INV_LATENCY = 5,
  parameter int FIFO_DEPTH  = 8,
  parameter int TAG_W       = 4,
  parameter int WARMUP      = 16
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic [31:0]      seed_i,
  input  logic             seed_load_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [7:0]       in_sh0_i,
  input  logic [7:0]       in_sh1_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic [7:0]       inv_sh0_o,
  output logic [7:0]       inv_sh1_o,
  output logic [7:0]       inv_guards_o,
  output logic [3:0]       inv_random_o,
  input  logic [7:0]       inv_res_sh0_i,
  input  logic [7:0]       inv_res_sh1_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [7:0]       out_sh0_o,
  output logic [7:0]       out_sh1_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic             busy_o
);

  localparam logic [1:0] ST_SEED  = 2'd0;
  localparam logic [1:0] ST_WARM  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // Stage k of the line is valid while the item is k cycles past issue; the
  // result is captured from the last stage.
  localparam int LINE_LEN = INV_LATENCY + 1;
  localparam int INFL_W   = $clog2(LINE_LEN + 1);
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int WARM_W   = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int SUM_W    = ((INFL_W > CNT_W) ? INFL_W : CNT_W) + 1;
  localparam int ENTRY_W  = TAG_W + 16;

  localparam logic [31:0]       POLY      = 32'h8020_0003;
  localparam logic [INFL_W-1:0] INFL_ONE  = 1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = 1;
  localparam logic [PTR_W-1:0]  PTR_ONE   = 1;
  localparam logic [WARM_W-1:0] WARM_ONE  = 1;
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);

  logic [1:0]          state;
  logic [WARM_W-1:0]   warm_cnt;
  logic                reseed_pend;
  logic [31:0]         lfsr;
  logic [31:0]         seed_val;

  logic [LINE_LEN-1:0] line_vld;
  logic [TAG_W-1:0]    line_tag [LINE_LEN];
  logic [INFL_W-1:0]   inflight;

  logic [ENTRY_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    fifo_count;
  logic [ENTRY_W-1:0]  head;
  logic [SUM_W-1:0]    credit_used;

  logic accept;
  logic push;
  logic pop;

  function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
    logic [31:0] x;
    x = s;
    for (int i = 0; i < 12; i++) x = x[0] ? ((x >> 1) ^ POLY) : (x >> 1);
    return x;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  assign seed_val     = (seed_i == 32'h0) ? 32'h0000_0001 : seed_i;
  assign credit_used  = SUM_W'(inflight) + SUM_W'(fifo_count);
  assign in_ready_o   = (state == ST_RUN) && (credit_used < SUM_W'(FIFO_DEPTH));
  assign accept       = in_valid_i && in_ready_o;
  assign push         = line_vld[LINE_LEN-1];
  assign out_valid_o  = (fifo_count != '0);
  assign pop          = out_valid_o && out_ready_i;
  assign busy_o       = (inflight != '0) || out_valid_o;
  assign inv_guards_o = lfsr[7:0];
  assign inv_random_o = lfsr[11:8];
  assign head         = fifo_mem[rd_ptr];
  assign {out_tag_o, out_sh0_o, out_sh1_o} = out_valid_o ? head : '0;

  // NOTE: every register here takes <=; the blocking loop inside lfsr_adv only
  // builds a combinational next-state value and never touches stored state.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state       <= ST_SEED;
      warm_cnt    <= '0;
      reseed_pend <= 1'b0;
      lfsr        <= '0;
    end else begin
      case (state)
        ST_SEED: begin
          if (seed_load_i || reseed_pend) begin
            state       <= ST_WARM;
            warm_cnt    <= '0;
            reseed_pend <= 1'b0;
            if (seed_load_i) lfsr <= seed_val;
          end
        end
        ST_WARM: begin
          lfsr <= lfsr_adv(lfsr);
          if (warm_cnt == WARM_LAST) state <= ST_RUN;
          else warm_cnt <= warm_cnt + WARM_ONE;
        end
        ST_RUN: begin
          lfsr <= lfsr_adv(lfsr);
          if (seed_load_i) state <= ST_DRAIN;
        end
        default: begin
          // Drain finished: reload the seed now and restart warm-up without a new pulse.
          if (!busy_o) begin
            state       <= ST_SEED;
            lfsr        <= seed_val;
            reseed_pend <= 1'b1;
          end else begin
            lfsr <= lfsr_adv(lfsr);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      inv_sh0_o <= '0;
      inv_sh1_o <= '0;
      line_vld  <= '0;
      inflight  <= '0;
    end else begin
      if (accept) begin
        inv_sh0_o <= in_sh0_i;
        inv_sh1_o <= in_sh1_i;
      end
      line_vld <= {line_vld[LINE_LEN-2:0], accept};
      case ({accept, push})
        2'b10:   inflight <= inflight + INFL_ONE;
        2'b01:   inflight <= inflight - INFL_ONE;
        default: ;
      endcase
    end
  end

  // NOTE: tag line and FIFO storage are deliberately not reset; line_vld and the
  // FIFO pointers decide what is live, so stale payload is never observed.
  always_ff @(posedge clk) begin
    line_tag[0] <= in_tag_i;
    for (int i = 1; i < LINE_LEN; i++) line_tag[i] <= line_tag[i-1];
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {line_tag[LINE_LEN-1], inv_res_sh0_i, inv_res_sh1_i};
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: ;
      endcase
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst_i)
    !(push && !pop && (fifo_count == CNT_W'(FIFO_DEPTH))));

endmodule
